// File: rtl/demux_ddr.sv
// DDR input demux: pairs the high-phase and low-phase halves of din and queues them in a FWFT FIFO.
// Latency: a pair is visible right after the posedge that completes it; the din path is never stalled.
// Backpressure: out_ready pops the head; a pair arriving at a full FIFO without a pop is dropped and flagged.
module demux_ddr #(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     din_valid,
   input  logic [width-1:0]         din,
   input  logic                     out_ready,
   input  logic                     overflow_clear,
   output logic                     out_valid,
   output logic                     rising_valid,
   output logic [width-1:0]         rising,
   output logic                     falling_valid,
   output logic [width-1:0]         falling,
   output logic                     overflow,
   output logic [$clog2(depth):0]   level
);

   localparam int AW = $clog2(depth);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL = LW'(depth);

   typedef struct packed {
      logic             r_vld;
      logic [width-1:0] r_dat;
      logic             f_vld;
      logic [width-1:0] f_dat;
   } pair_t;

   logic             r_valid;
   logic [width-1:0] r_data;
   logic             armed;

   // armed blocks pairing until a negedge has captured a post-reset high phase
   always_ff @(negedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         armed   <= 1'b0;
      end else begin
         r_valid <= din_valid;
         r_data  <= din;
         armed   <= 1'b1;
      end
   end

   pair_t           mem [depth];
   pair_t           in_pair;
   pair_t           head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [LW-1:0]   level_nxt;
   logic            push;
   logic            pop;
   logic            full;
   logic            wr_en;
   logic            drop;

   assign in_pair = {r_valid, r_data, din_valid, din};
   assign push    = armed & (r_valid | din_valid);
   assign pop     = out_valid & out_ready;
   assign full    = (level == FULL_LVL);
   assign wr_en   = push & (~full | pop);
   assign drop    = push & full & ~pop;

   always_comb begin
      level_nxt = level;
      if (wr_en && !pop)
         level_nxt = level + LW'(1);
      else if (!wr_en && pop)
         level_nxt = level - LW'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         level <= level_nxt;
         // a drop in the same cycle as a clear keeps the flag set
         if (drop)
            overflow <= 1'b1;
         else if (overflow_clear)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem[wr_ptr] <= in_pair;
   end

   assign head          = mem[rd_ptr];
   assign out_valid     = (level != '0);
   assign rising_valid  = out_valid & head.r_vld;
   assign falling_valid = out_valid & head.f_vld;
   assign rising        = out_valid ? head.r_dat : '0;
   assign falling       = out_valid ? head.f_dat : '0;

endmodule

// File: tb/tb_demux_ddr.sv
// Bench for demux_ddr: directed scenarios plus randomized traffic against a queue-based model.
module tb_demux_ddr;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          din_valid;
   logic [W-1:0]  din;
   logic          out_ready;
   logic          overflow_clear;
   logic          out_valid;
   logic          rising_valid;
   logic [W-1:0]  rising;
   logic          falling_valid;
   logic [W-1:0]  falling;
   logic          overflow;
   logic [LW-1:0] level;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      logic         rv;
      logic [W-1:0] rd;
      logic         fv;
      logic [W-1:0] fd;
   } pair_m;

   pair_m q[$];
   logic  m_ovf = 1'b0;

   demux_ddr #(.width(W), .depth(DEPTH)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .din_valid      (din_valid),
      .din            (din),
      .out_ready      (out_ready),
      .overflow_clear (overflow_clear),
      .out_valid      (out_valid),
      .rising_valid   (rising_valid),
      .rising         (rising),
      .falling_valid  (falling_valid),
      .falling        (falling),
      .overflow       (overflow),
      .level          (level)
   );

   always #5 clock = ~clock;

   // Called at posedge+1: drives one high/low half pair, updates the model, returns at the next posedge+1.
   task automatic cyc(input logic rv, input logic [W-1:0] rd, input logic fv,
                      input logic [W-1:0] fd, input logic ordy, input logic clr);
      bit    do_pop, do_push, is_full, do_drop;
      pair_m p;
      din_valid = rv; din = rd; out_ready = ordy; overflow_clear = clr;
      @(negedge clock); #1;
      din_valid = fv; din = fd;
      do_pop  = (q.size() != 0) && ordy;
      do_push = rv || fv;
      is_full = (q.size() == DEPTH);
      do_drop = do_push && is_full && !do_pop;
      if (do_pop) q.delete(0);
      if (do_push && !do_drop) begin
         p.rv = rv; p.rd = rd; p.fv = fv; p.fd = fd;
         q.push_back(p);
      end
      if (do_drop) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      @(posedge clock); #1;
      din_valid = 1'b0; overflow_clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; din_valid = 1'b0; din = '0; out_ready = 1'b0; overflow_clear = 1'b0;
      #2;
      n_run++;
      if ({out_valid, rising_valid, falling_valid, overflow} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags got %b want 0000", {out_valid, rising_valid, falling_valid, overflow});
      end
      n_run++;
      if (level !== '0 || rising !== '0 || falling !== '0) begin
         n_fail++; $display("FAIL reset_data got level=%0d rising=%h falling=%h want 0 0 0", level, rising, falling);
      end
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_stream();
      logic [W-1:0] er, ef;
      for (int k = 1; k <= 3; k++) begin
         er = W'(8'h11 * k);
         ef = W'(8'hA0 + k);
         cyc(1'b1, er, 1'b1, ef, 1'b1, 1'b0);
         n_run++;
         if (out_valid !== 1'b1 || level !== LW'(1)) begin
            n_fail++; $display("FAIL stream_level k=%0d got vld=%b level=%0d want 1 1", k, out_valid, level);
         end
         n_run++;
         if (rising !== er || falling !== ef || rising_valid !== 1'b1 || falling_valid !== 1'b1) begin
            n_fail++; $display("FAIL stream_data k=%0d got %h/%h want %h/%h", k, rising, falling, er, ef);
         end
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      n_run++;
      if (out_valid !== 1'b0 || rising_valid !== 1'b0 || falling_valid !== 1'b0) begin
         n_fail++; $display("FAIL stream_drain got vld=%b rv=%b fv=%b want 0 0 0", out_valid, rising_valid, falling_valid);
      end
   endtask

   task automatic test_partial();
      cyc(1'b0, W'($urandom), 1'b1, 8'h5C, 1'b0, 1'b0);
      n_run++;
      if (level !== LW'(1) || rising_valid !== 1'b0 || falling_valid !== 1'b1 || falling !== 8'h5C) begin
         n_fail++; $display("FAIL partial_entry got level=%0d rv=%b fv=%b f=%h want 1 0 1 5c",
                            level, rising_valid, falling_valid, falling);
      end
      repeat (2) cyc(1'b0, W'($urandom), 1'b0, W'($urandom), 1'b0, 1'b0);
      n_run++;
      if (level !== LW'(1)) begin
         n_fail++; $display("FAIL partial_idle got level=%0d want 1", level);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      n_run++;
      if (level !== '0) begin
         n_fail++; $display("FAIL partial_drain got level=%0d want 0", level);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] exp_seq [4];
      for (int k = 1; k <= 5; k++)
         cyc(1'b1, W'(k), 1'b1, W'(8'hF0 | k), 1'b0, 1'b0);
      n_run++;
      if (level !== LW'(4) || overflow !== 1'b1) begin
         n_fail++; $display("FAIL ovf_set got level=%0d ovf=%b want 4 1", level, overflow);
      end
      n_run++;
      if (rising !== 8'h01 || falling !== 8'hF1) begin
         n_fail++; $display("FAIL ovf_head got %h/%h want 01/f1", rising, falling);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      n_run++;
      if (overflow !== 1'b0 || level !== LW'(4)) begin
         n_fail++; $display("FAIL ovf_clear got ovf=%b level=%0d want 0 4", overflow, level);
      end
      cyc(1'b1, 8'h07, 1'b1, 8'hF7, 1'b0, 1'b1);
      n_run++;
      if (overflow !== 1'b1 || level !== LW'(4) || rising !== 8'h01) begin
         n_fail++; $display("FAIL ovf_set_wins got ovf=%b level=%0d head=%h want 1 4 01", overflow, level, rising);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      cyc(1'b1, 8'h06, 1'b1, 8'hF6, 1'b1, 1'b0);
      n_run++;
      if (level !== LW'(4) || overflow !== 1'b0 || rising !== 8'h02) begin
         n_fail++; $display("FAIL full_pop got level=%0d ovf=%b head=%h want 4 0 02", level, overflow, rising);
      end
      exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h06;
      for (int i = 0; i < 4; i++) begin
         n_run++;
         if (out_valid !== 1'b1 || rising !== exp_seq[i] || falling !== (exp_seq[i] | 8'hF0)) begin
            n_fail++; $display("FAIL drain_order i=%0d got vld=%b %h/%h want 1 %h/%h", i, out_valid, rising,
                               falling, exp_seq[i], exp_seq[i] | 8'hF0);
         end
         cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
      end
      n_run++;
      if (out_valid !== 1'b0 || level !== '0) begin
         n_fail++; $display("FAIL drain_empty got vld=%b level=%0d want 0 0", out_valid, level);
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++)
         cyc(1'b1, W'($urandom), 1'b1, W'($urandom), 1'b0, 1'b0);
      n_run++;
      if (level !== LW'(3)) begin
         n_fail++; $display("FAIL mid_fill got level=%0d want 3", level);
      end
      reset_n = 1'b0; din_valid = 1'b1; din = 8'h77;
      #1;
      n_run++;
      if (out_valid !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL mid_async got vld=%b level=%0d ovf=%b want 0 0 0", out_valid, level, overflow);
      end
      q.delete(); m_ovf = 1'b0;
      @(negedge clock); #1;
      reset_n = 1'b1; din_valid = 1'b1; din = 8'hEE;
      @(posedge clock); #1;
      n_run++;
      if (level !== '0) begin
         n_fail++; $display("FAIL mid_no_early_push got level=%0d want 0", level);
      end
      cyc(1'b1, 8'h3C, 1'b1, 8'hC3, 1'b0, 1'b0);
      n_run++;
      if (level !== LW'(1) || rising !== 8'h3C || falling !== 8'hC3) begin
         n_fail++; $display("FAIL mid_first_pair got level=%0d %h/%h want 1 3c/c3", level, rising, falling);
      end
      cyc(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), W'($urandom),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
         n_run++;
         if (out_valid !== (q.size() != 0) || level !== LW'(q.size()) || overflow !== m_ovf) begin
            n_fail++; $display("FAIL rand_state i=%0d got vld=%b level=%0d ovf=%b want %b %0d %b",
                               i, out_valid, level, overflow, q.size() != 0, q.size(), m_ovf);
         end
         if (q.size() != 0) begin
            n_run++;
            if (rising_valid !== q[0].rv || falling_valid !== q[0].fv ||
                (q[0].rv && rising !== q[0].rd) || (q[0].fv && falling !== q[0].fd)) begin
               n_fail++; $display("FAIL rand_head i=%0d got %b:%h %b:%h want %b:%h %b:%h", i, rising_valid,
                                  rising, falling_valid, falling, q[0].rv, q[0].rd, q[0].fv, q[0].fd);
            end
         end else begin
            n_run++;
            if (rising_valid !== 1'b0 || falling_valid !== 1'b0) begin
               n_fail++; $display("FAIL rand_empty i=%0d got rv=%b fv=%b want 0 0", i, rising_valid, falling_valid);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_partial();
      test_overflow();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
